alu_iter: RTL and testbench

- Parametrised, sequential successor to the vanilla-core combinational integer ALU.
- Executes RV32-style base integer ops in one cycle and M-extension multiply/divide iteratively, all behind one valid/ready input and valid/yumi output handshake.
- Sits in the execute stage as a long-latency functional unit; a tag is carried through so the core can route the writeback.

---
 rtl/alu_iter_pkg.sv | 40 ++++
 rtl/alu_iter_if.sv | 30 +++
 rtl/alu_iter_muldiv.sv | 84 ++++++++
 rtl/alu_iter.sv | 174 +++++++++++++++++
 tb/tb_alu_iter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_iter_pkg.sv
// Shared types for the iterative integer ALU: opcodes, FSM states and the
// iteration-counter width helper.
package alu_iter_pkg;

  localparam int unsigned default_width_lp = 32;

  typedef enum logic [4:0] {
    eOpAdd    = 5'd0,
    eOpSub    = 5'd1,
    eOpSlt    = 5'd2,
    eOpSltu   = 5'd3,
    eOpXor    = 5'd4,
    eOpOr     = 5'd5,
    eOpAnd    = 5'd6,
    eOpSll    = 5'd7,
    eOpSrl    = 5'd8,
    eOpSra    = 5'd9,
    eOpMul    = 5'd10,
    eOpMulh   = 5'd11,
    eOpMulhu  = 5'd12,
    eOpMulhsu = 5'd13,
    eOpDiv    = 5'd14,
    eOpDivu   = 5'd15,
    eOpRem    = 5'd16,
    eOpRemu   = 5'd17
  } alu_iter_op_e;

  typedef enum logic [2:0] {
    eIdle,
    eMul,
    eDiv,
    eFix,
    eDone
  } alu_iter_state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Request (valid/ready) and result (valid/yumi) handshake bundle of alu_iter.
interface alu_iter_if
  import alu_iter_pkg::*;
#(
  parameter int unsigned width_p     = default_width_lp,
  parameter int unsigned tag_width_p = 5
) ();

  logic                   v_i;
  logic                   ready_o;
  alu_iter_op_e           op_i;
  logic [width_p-1:0]     rs1_i;
  logic [width_p-1:0]     rs2_i;
  logic [tag_width_p-1:0] tag_i;
  logic                   v_o;
  logic [width_p-1:0]     result_o;
  logic [tag_width_p-1:0] tag_o;
  logic                   yumi_i;

  modport slave (
    input  v_i, op_i, rs1_i, rs2_i, tag_i, yumi_i,
    output ready_o, v_o, result_o, tag_o
  );

  modport master (
    output v_i, op_i, rs1_i, rs2_i, tag_i, yumi_i,
    input  ready_o, v_o, result_o, tag_o
  );

endinterface

// File: rtl/alu_iter_muldiv.sv
// Shared shift-add multiplier / restoring divider on unsigned magnitudes,
// with one add/sub datapath and the iteration counter.
module alu_iter_muldiv
  import alu_iter_pkg::*;
#(
  parameter int unsigned width_p     = default_width_lp,
  parameter int unsigned early_out_p = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 mul_busy,
  input  logic                 div_busy,
  input  logic [width_p-1:0]   opa,
  input  logic [width_p-1:0]   opb,
  output logic                 last,
  output logic [2*width_p-1:0] prod,
  output logic [width_p-1:0]   quot,
  output logic [width_p-1:0]   rem
);

  localparam int unsigned cnt_w_lp = cnt_width(width_p);
  localparam int unsigned dw_lp    = 2 * width_p;

  typedef logic [dw_lp:0] wide_t;

  // sr_r: left-shifting multiplicand (mul) or {remainder, quotient} (div)
  logic [dw_lp-1:0]    sr_r;
  logic [dw_lp-1:0]    acc_r;
  logic [width_p-1:0]  b_r;
  logic [cnt_w_lp-1:0] cnt_r;

  wide_t               add_a, add_b, sum;
  logic [width_p:0]    rem_sh;
  logic                qbit;
  logic [width_p-1:0]  rem_n;
  logic [dw_lp-1:0]    sr_div;

  always_comb begin
    rem_sh = {sr_r[dw_lp-1:width_p], sr_r[width_p-1]};
    if (div_busy) begin
      add_a = {{width_p{1'b0}}, rem_sh};
      add_b = ~{{(width_p + 1){1'b0}}, b_r};
    end else begin
      add_a = {1'b0, acc_r};
      add_b = {1'b0, sr_r};
    end
    sum    = add_a + add_b + wide_t'(div_busy);
    qbit   = ~sum[dw_lp];
    rem_n  = qbit ? sum[width_p-1:0] : rem_sh[width_p-1:0];
    sr_div = {rem_n, sr_r[width_p-2:0], qbit};
    prod   = b_r[0] ? sum[dw_lp-1:0] : acc_r;
    last   = (cnt_r == cnt_w_lp'(width_p - 1)) ||
             (mul_busy && (early_out_p != 0) && (b_r[width_p-1:1] == '0));
  end

  assign quot = sr_r[width_p-1:0];
  assign rem  = sr_r[dw_lp-1:width_p];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr_r  <= '0;
      acc_r <= '0;
      b_r   <= '0;
      cnt_r <= '0;
    end else if (start) begin
      sr_r  <= {{width_p{1'b0}}, opa};
      acc_r <= '0;
      b_r   <= opb;
      cnt_r <= '0;
    end else if (mul_busy) begin
      acc_r <= prod;
      sr_r  <= {sr_r[dw_lp-2:0], 1'b0};
      b_r   <= b_r >> 1;
      cnt_r <= cnt_r + 1'b1;
    end else if (div_busy) begin
      sr_r  <= sr_div;
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= '0;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Iterative RV32-style ALU: single-cycle base ops, multi-cycle M-extension ops.
// Optional macro ALU_ITER_PERF_CNT_EN adds busy/stall performance counters.
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int unsigned width_p     = default_width_lp,
  parameter int unsigned tag_width_p = 5,
  parameter int unsigned early_out_p = 1
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  alu_iter_if.slave   bus
`ifdef ALU_ITER_PERF_CNT_EN
  ,
  output logic [31:0] busy_cycles_o,
  output logic [31:0] stall_cycles_o
`endif
);

  localparam int unsigned sh_w_lp = $clog2(width_p);

  alu_iter_state_e state_r, state_n;
  logic ready, accept;

  logic [width_p-1:0]     rs1, rs2, alu_res, special_res;
  logic [width_p-1:0]     opa_mag, opb_mag, mul_res, div_res;
  logic [width_p-1:0]     result_r, md_quot, md_rem;
  logic [tag_width_p-1:0] tag_r;
  logic [2*width_p-1:0]   md_prod, prod_s;
  logic [width_p:0]       diff;
  logic [sh_w_lp-1:0]     shamt;
  logic                   is_mul, is_div, sgn_a, sgn_b, sel_upper, ext;
  logic                   neg_a, neg_b, div_zero, div_ovf, div_special, md_last;
  logic                   neg_r, neg_rem_r, upper_r, special_r;

  assign rs1 = bus.rs1_i;
  assign rs2 = bus.rs2_i;

  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    sgn_a     = 1'b0;
    sgn_b     = 1'b0;
    sel_upper = 1'b0;
    case (bus.op_i)
      eOpMul:    is_mul = 1'b1;
      eOpMulh:   begin is_mul = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; sel_upper = 1'b1; end
      eOpMulhu:  begin is_mul = 1'b1; sel_upper = 1'b1; end
      eOpMulhsu: begin is_mul = 1'b1; sgn_a = 1'b1; sel_upper = 1'b1; end
      eOpDiv:    begin is_div = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      eOpDivu:   is_div = 1'b1;
      eOpRem:    begin is_div = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; sel_upper = 1'b1; end
      eOpRemu:   begin is_div = 1'b1; sel_upper = 1'b1; end
      default:   ;
    endcase
  end

  // One (width_p+1)-bit subtractor serves SUB, SLT (sign-extended) and SLTU.
  always_comb begin
    ext   = (bus.op_i == eOpSlt);
    diff  = {ext & rs1[width_p-1], rs1} - {ext & rs2[width_p-1], rs2};
    shamt = rs2[sh_w_lp-1:0];
    case (bus.op_i)
      eOpSub:  alu_res = diff[width_p-1:0];
      eOpSlt,
      eOpSltu: alu_res = {{(width_p - 1){1'b0}}, diff[width_p]};
      eOpXor:  alu_res = rs1 ^ rs2;
      eOpOr:   alu_res = rs1 | rs2;
      eOpAnd:  alu_res = rs1 & rs2;
      eOpSll:  alu_res = rs1 << shamt;
      eOpSrl:  alu_res = rs1 >> shamt;
      eOpSra:  alu_res = $unsigned($signed(rs1) >>> shamt);
      default: alu_res = rs1 + rs2;
    endcase
  end

  assign neg_a       = sgn_a & rs1[width_p-1];
  assign neg_b       = sgn_b & rs2[width_p-1];
  assign opa_mag     = neg_a ? -rs1 : rs1;
  assign opb_mag     = neg_b ? -rs2 : rs2;
  assign div_zero    = is_div & (rs2 == '0);
  assign div_ovf     = is_div & sgn_a & (rs1 == {1'b1, {(width_p - 1){1'b0}}}) & (rs2 == '1);
  assign div_special = div_zero | div_ovf;
  assign special_res = div_zero ? (sel_upper ? rs1 : '1) : (sel_upper ? '0 : rs1);

  always_comb begin
    state_n = state_r;
    ready   = 1'b0;
    case (state_r)
      eIdle: ready = 1'b1;
      eMul:  if (md_last) state_n = eDone;
      eDiv:  if (md_last) state_n = eFix;
      eFix:  state_n = eDone;
      eDone: if (bus.yumi_i) begin ready = 1'b1; state_n = eIdle; end
      default: state_n = eIdle;
    endcase
    accept = bus.v_i & ready;
    if (accept) begin
      if (is_mul)           state_n = eMul;
      else if (div_special) state_n = eFix;
      else if (is_div)      state_n = eDiv;
      else                  state_n = eDone;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_r <= eIdle;
    else            state_r <= state_n;
  end

  alu_iter_muldiv #(
    .width_p     (width_p),
    .early_out_p (early_out_p)
  ) muldiv (
    .clk      (clk_i),
    .reset_n  (reset_n_i),
    .start    (accept & (is_mul | (is_div & ~div_special))),
    .mul_busy (state_r == eMul),
    .div_busy (state_r == eDiv),
    .opa      (opa_mag),
    .opb      (opb_mag),
    .last     (md_last),
    .prod     (md_prod),
    .quot     (md_quot),
    .rem      (md_rem)
  );

  assign prod_s  = neg_r ? -md_prod : md_prod;
  assign mul_res = upper_r ? prod_s[2*width_p-1:width_p] : prod_s[width_p-1:0];
  assign div_res = upper_r ? (neg_rem_r ? -md_rem : md_rem) : (neg_r ? -md_quot : md_quot);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      result_r  <= '0;
      tag_r     <= '0;
      neg_r     <= 1'b0;
      neg_rem_r <= 1'b0;
      upper_r   <= 1'b0;
      special_r <= 1'b0;
    end else begin
      if (accept) begin
        tag_r     <= bus.tag_i;
        neg_r     <= neg_a ^ neg_b;
        neg_rem_r <= neg_a;
        upper_r   <= sel_upper;
        special_r <= div_special;
        if (div_special)            result_r <= special_res;
        else if (!is_mul && !is_div) result_r <= alu_res;
      end
      if (state_r == eMul && md_last)    result_r <= mul_res;
      if (state_r == eFix && !special_r) result_r <= div_res;
    end
  end

  assign bus.ready_o  = ready;
  assign bus.v_o      = (state_r == eDone);
  assign bus.result_o = result_r;
  assign bus.tag_o    = tag_r;

`ifdef ALU_ITER_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      busy_cycles_o  <= '0;
      stall_cycles_o <= '0;
    end else begin
      if ((state_r inside {eMul, eDiv, eFix}) && busy_cycles_o != '1)
        busy_cycles_o <= busy_cycles_o + 32'd1;
      if (state_r == eDone && !bus.yumi_i && stall_cycles_o != '1)
        stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter (default parameters, early-out on).
module tb_alu_iter;
  import alu_iter_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_iter_if #(.width_p(32), .tag_width_p(5)) bus ();

`ifdef ALU_ITER_PERF_CNT_EN
  logic [31:0] busy_cycles, stall_cycles;
`endif

  alu_iter #(
    .width_p     (32),
    .tag_width_p (5),
    .early_out_p (1)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
`ifdef ALU_ITER_PERF_CNT_EN
    ,
    .busy_cycles_o  (busy_cycles),
    .stall_cycles_o (stall_cycles)
`endif
  );

  typedef struct {
    alu_iter_op_e op;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [31:0]  want;
    int           lat;
  } vec_t;

  task automatic issue(input alu_iter_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    bus.v_i   = 1'b1;
    bus.op_i  = op;
    bus.rs1_i = a;
    bus.rs2_i = b;
    bus.tag_i = tag;
    @(posedge clk); #1;
    bus.v_i = 1'b0;
  endtask

  // Latency counts clock edges from the accepting edge up to v_o, bounded.
  task automatic wait_result(output int lat);
    lat = 1;
    while (bus.v_o !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    bus.yumi_i = 1'b1;
    @(posedge clk); #1;
    bus.yumi_i = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    reset_n    = 1'b0;
    bus.v_i    = 1'b1;
    bus.op_i   = eOpAdd;
    bus.rs1_i  = 32'd1;
    bus.rs2_i  = 32'd1;
    bus.tag_i  = 5'd7;
    bus.yumi_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.v_o !== 1'b0 || bus.ready_o !== 1'b1) begin
        bad++;
        $display("FAIL reset[%0d] v_o=%b ready_o=%b want v_o=0 ready_o=1", i, bus.v_o, bus.ready_o);
      end
    end
    total++;
    if (bus.result_o !== 32'd0 || bus.tag_o !== 5'd0) begin
      bad++;
      $display("FAIL reset_outputs result=%h tag=%0d want 0/0", bus.result_o, bus.tag_o);
    end
    bus.v_i = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.v_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_release v_o=%b want 0", bus.v_o);
    end
    issue(eOpAdd, 32'd5, 32'd7, 5'd3);
    wait_result(lat);
    total++;
    if (lat != 1 || bus.result_o !== 32'd12 || bus.tag_o !== 5'd3) begin
      bad++;
      $display("FAIL add_first lat=%0d result=%h tag=%0d want lat=1 result=0000000c tag=3",
               lat, bus.result_o, bus.tag_o);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    vec_t v [6];
    v = '{'{eOpSub,  32'd0,          32'd1,  32'hFFFFFFFF, 1},
          '{eOpSltu, 32'd0,          32'd1,  32'd1,        1},
          '{eOpSra,  32'h80000000,   32'd4,  32'hF8000000, 1},
          '{eOpSll,  32'd1,          32'h21, 32'd2,        1},
          '{eOpSlt,  32'hFFFFFFFF,   32'd1,  32'd1,        1},
          '{alu_iter_op_e'(5'd31), 32'd2, 32'd3, 32'd5,    1}};
    bus.yumi_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.v_i   = 1'b1;
      bus.op_i  = v[i].op;
      bus.rs1_i = v[i].a;
      bus.rs2_i = v[i].b;
      bus.tag_i = 5'(i + 10);
      @(posedge clk); #1;
      total++;
      if (bus.v_o !== 1'b1 || bus.result_o !== v[i].want || bus.tag_o !== 5'(i + 10) ||
          bus.ready_o !== 1'b1) begin
        bad++;
        $display("FAIL b2b[%0d] v_o=%b ready_o=%b result=%h tag=%0d want v_o=1 ready_o=1 result=%h tag=%0d",
                 i, bus.v_o, bus.ready_o, bus.result_o, bus.tag_o, v[i].want, i + 10);
      end
    end
    bus.v_i = 1'b0;
    @(posedge clk); #1;
    bus.yumi_i = 1'b0;
    total++;
    if (bus.v_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain v_o=%b want 0", bus.v_o);
    end
  endtask

  task automatic test_mul();
    vec_t v [5];
    int   lat;
    v = '{'{eOpMulh,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 3},
          '{eOpMul,    32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 3},
          '{eOpMulhu,  32'hFFFFFFFF, 32'd1,        32'd0,        2},
          '{eOpMulhu,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33},
          '{eOpMulhsu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33}};
    for (int i = 0; i < 5; i++) begin
      issue(v[i].op, v[i].a, v[i].b, 5'(i + 1));
      wait_result(lat);
      total++;
      if (lat != v[i].lat || bus.result_o !== v[i].want || bus.tag_o !== 5'(i + 1)) begin
        bad++;
        $display("FAIL mul[%0d] lat=%0d result=%h tag=%0d want lat=%0d result=%h tag=%0d",
                 i, lat, bus.result_o, bus.tag_o, v[i].lat, v[i].want, i + 1);
      end
      consume();
    end
  endtask

  task automatic test_div();
    vec_t v [9];
    int   lat;
    v = '{'{eOpDiv,  32'd7,        32'd0,        32'hFFFFFFFF, 2},
          '{eOpRem,  32'd7,        32'd0,        32'd7,        2},
          '{eOpDivu, 32'd7,        32'd0,        32'hFFFFFFFF, 2},
          '{eOpDiv,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2},
          '{eOpRem,  32'h80000000, 32'hFFFFFFFF, 32'd0,        2},
          '{eOpRem,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34},
          '{eOpDiv,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34},
          '{eOpDivu, 32'd100,      32'd7,        32'd14,       34},
          '{eOpRemu, 32'd100,      32'd7,        32'd2,        34}};
    for (int i = 0; i < 9; i++) begin
      issue(v[i].op, v[i].a, v[i].b, 5'(i + 16));
      wait_result(lat);
      total++;
      if (lat != v[i].lat || bus.result_o !== v[i].want || bus.tag_o !== 5'(i + 16)) begin
        bad++;
        $display("FAIL div[%0d] lat=%0d result=%h tag=%0d want lat=%0d result=%h tag=%0d",
                 i, lat, bus.result_o, bus.tag_o, v[i].lat, v[i].want, i + 16);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
`ifdef ALU_ITER_PERF_CNT_EN
    logic [31:0] busy0, stall0;
    busy0  = busy_cycles;
    stall0 = stall_cycles;
`endif
    issue(eOpDivu, 32'd100, 32'd7, 5'd9);
    wait_result(lat);
    total++;
    if (lat != 34 || bus.result_o !== 32'd14 || bus.ready_o !== 1'b0) begin
      bad++;
      $display("FAIL bp_first lat=%0d result=%h ready_o=%b want lat=34 result=0000000e ready_o=0",
               lat, bus.result_o, bus.ready_o);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.v_o !== 1'b1 || bus.result_o !== 32'd14 || bus.tag_o !== 5'd9 ||
          bus.ready_o !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d] v_o=%b result=%h tag=%0d ready_o=%b want 1/0000000e/9/0",
                 i, bus.v_o, bus.result_o, bus.tag_o, bus.ready_o);
      end
    end
    bus.yumi_i = 1'b1;
    #1;
    total++;
    if (bus.ready_o !== 1'b1) begin
      bad++;
      $display("FAIL bp_ready_on_yumi ready_o=%b want 1", bus.ready_o);
    end
    @(posedge clk); #1;
    bus.yumi_i = 1'b0;
    total++;
    if (bus.v_o !== 1'b0) begin
      bad++;
      $display("FAIL bp_release v_o=%b want 0", bus.v_o);
    end
`ifdef ALU_ITER_PERF_CNT_EN
    total++;
    if (stall_cycles - stall0 !== 32'd5 || busy_cycles - busy0 !== 32'd33) begin
      bad++;
      $display("FAIL perf_counts stall=%0d busy=%0d want stall=5 busy=33",
               stall_cycles - stall0, busy_cycles - busy0);
    end
`endif
  endtask

  task automatic test_reset_mid_div();
    int lat;
    bit quiet;
    issue(eOpDivu, 32'd100, 32'd7, 5'd4);
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.v_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.result_o !== 32'd0 || bus.tag_o !== 5'd0) begin
      bad++;
      $display("FAIL mid_reset v_o=%b ready_o=%b result=%h tag=%0d want 0/1/00000000/0",
               bus.v_o, bus.ready_o, bus.result_o, bus.tag_o);
    end
`ifdef ALU_ITER_PERF_CNT_EN
    total++;
    if (busy_cycles !== 32'd0 || stall_cycles !== 32'd0) begin
      bad++;
      $display("FAIL perf_clear busy=%0d stall=%0d want 0/0", busy_cycles, stall_cycles);
    end
`endif
    reset_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.v_o !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_quiet v_o rose after abort, want v_o=0 throughout");
    end
    issue(eOpAdd, 32'd20, 32'd22, 5'd1);
    wait_result(lat);
    total++;
    if (lat != 1 || bus.result_o !== 32'd42 || bus.tag_o !== 5'd1) begin
      bad++;
      $display("FAIL post_reset_add lat=%0d result=%h tag=%0d want lat=1 result=0000002a tag=1",
               lat, bus.result_o, bus.tag_o);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
